// File: rtl/operand_pkg.sv
// operand_pkg: shared mode encodings and defaults for the operand multiplexer
package operand_pkg;
  typedef enum logic {MODE_DIRECT = 1'b0, MODE_RR = 1'b1} mode_e;
  localparam int DEFAULT_WIDTH = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority encoder searching last+1, last+2, ... modulo N
module rr_pick #(
  parameter int N = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  // scan from farthest to nearest so the nearest requester after last wins
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        found = 1'b1;
        idx = SEL_W'((int'(last) + k) % N);
      end
    end
  end
endmodule

// File: rtl/operand_mux_arb.sv
// operand_mux_arb: registered N-channel operand mux with directed and round-robin selection
module operand_mux_arb import operand_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHANNELS = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      Mode,
  input  logic [SEL_W-1:0]          Selector,
  input  logic [CHANNELS-1:0]       InValid,
  input  logic [CHANNELS*WIDTH-1:0] InData,
  output logic [CHANNELS-1:0]       InReady,
  output logic                      OutValid,
  output logic [WIDTH-1:0]          OutData,
  input  logic                      OutReady,
  output logic [SEL_W-1:0]          Grant
);
  localparam int PAD = 1 << SEL_W;
  logic free, rr_found, dir_ok, has, accept;
  logic [SEL_W-1:0] rr_idx, cand, last;
  logic [PAD-1:0] valid_pad;
  logic [WIDTH-1:0] sel_data;

  rr_pick #(.N(CHANNELS), .SEL_W(SEL_W)) u_pick (
    .req(InValid),
    .last(last),
    .found(rr_found),
    .idx(rr_idx)
  );

  // zero padding makes an out-of-range Selector see an idle channel
  assign valid_pad = PAD'(InValid);
  assign dir_ok = valid_pad[Selector];
  assign free = !OutValid || OutReady;
  assign cand = (Mode == MODE_RR) ? rr_idx : Selector;
  assign has = (Mode == MODE_RR) ? rr_found : dir_ok;
  assign accept = free && has && !Reset;
  assign InReady = accept ? (CHANNELS'(1) << cand) : '0;

  // data mux for the chosen channel; only consumed on accept
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (cand == SEL_W'(i)) sel_data = InData[i*WIDTH +: WIDTH];
  end

  // output stage and round-robin pointer
  always_ff @(posedge CLK) begin
    if (Reset) begin
      OutValid <= 1'b0;
      OutData <= '0;
      Grant <= '0;
      last <= SEL_W'(CHANNELS - 1);
    end else if (accept) begin
      OutValid <= 1'b1;
      OutData <= sel_data;
      Grant <= cand;
      if (Mode == MODE_RR) last <= cand;
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_operand_mux_arb.sv
// tb_operand_mux_arb: directed vectors with hand-computed expectations
module tb_operand_mux_arb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mode = 1'b0;
  logic [1:0] sel = '0;
  logic [3:0] in_valid = '0;
  logic [63:0] in_data = {16'h3D3D, 16'h2C2C, 16'h1B1B, 16'h0A0A};
  logic [3:0] in_ready;
  logic out_valid;
  logic [15:0] out_data;
  logic out_ready = 1'b0;
  logic [1:0] grant;
  logic [1:0] sel3 = '0;
  logic [2:0] in_valid3 = '0;
  logic [47:0] in_data3 = {16'h2222, 16'h1111, 16'h0000};
  logic [2:0] in_ready3;
  logic out_valid3;
  logic [15:0] out_data3;
  logic [1:0] grant3;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_mux_arb #(.WIDTH(16), .CHANNELS(4)) dut (
    .CLK(clk), .Reset(reset), .Mode(mode), .Selector(sel),
    .InValid(in_valid), .InData(in_data), .InReady(in_ready),
    .OutValid(out_valid), .OutData(out_data), .OutReady(out_ready), .Grant(grant)
  );

  operand_mux_arb #(.WIDTH(16), .CHANNELS(3)) dut3 (
    .CLK(clk), .Reset(reset), .Mode(1'b0), .Selector(sel3),
    .InValid(in_valid3), .InData(in_data3), .InReady(in_ready3),
    .OutValid(out_valid3), .OutData(out_data3), .OutReady(1'b1), .Grant(grant3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with all channels valid
    mode = 1'b1;
    in_valid = 4'hF;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ready", 32'(in_ready), 0);
    reset = 1'b0;
    #1;
    // round-robin fairness 0,1,2,3,0,1
    for (int k = 0; k < 6; k++) begin
      chk("rr_ready", 32'(in_ready), 32'(1) << (k % 4));
      tick();
      chk("rr_grant", 32'(grant), 32'(k % 4));
      chk("rr_valid", 32'(out_valid), 1);
    end
    chk("rr_data", 32'(out_data), 32'h1B1B);
    // directed back-to-back on channel 2; pointer stays at 1
    mode = 1'b0;
    sel = 2'd2;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("dir_ready", 32'(in_ready), 32'b0100);
      tick();
      chk("dir_data", 32'(out_data), 32'h2C2C);
      chk("dir_grant", 32'(grant), 2);
      chk("dir_valid", 32'(out_valid), 1);
    end
    // back in round-robin the search resumes after channel 1
    mode = 1'b1;
    #1;
    chk("rr_resume", 32'(in_ready), 32'b0100);
    tick();
    in_valid = 4'b0001;
    #1;
    chk("rr_only0", 32'(in_ready), 32'b0001);
    tick();
    // wrap and skip from last=0
    in_valid = 4'b1001;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("wrap_ready", 32'(in_ready), (k % 2 == 0) ? 32'b1000 : 32'b0001);
      tick();
      chk("wrap_grant", 32'(grant), (k % 2 == 0) ? 32'd3 : 32'd0);
    end
    // load 1B1B then stall
    mode = 1'b0;
    sel = 2'd1;
    in_valid = 4'hF;
    tick();
    chk("bp_load", 32'(out_data), 32'h1B1B);
    out_ready = 1'b0;
    sel = 2'd3;
    for (int k = 0; k < 4; k++) begin
      in_valid = (k == 0) ? 4'hF : (k == 1) ? 4'h3 : (k == 2) ? 4'hC : 4'h8;
      #1;
      chk("bp_ready", 32'(in_ready), 0);
      tick();
      chk("bp_data", 32'(out_data), 32'h1B1B);
      chk("bp_grant", 32'(grant), 1);
      chk("bp_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    in_valid = 4'b1000;
    #1;
    chk("bp_release", 32'(in_ready), 32'b1000);
    tick();
    chk("bp_next", 32'(out_data), 32'h3D3D);
    chk("bp_ngrant", 32'(grant), 3);
    // drain without refill holds data and grant
    in_valid = 4'b0000;
    #1;
    chk("drain_ready", 32'(in_ready), 0);
    tick();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_data", 32'(out_data), 32'h3D3D);
    chk("drain_grant", 32'(grant), 3);
    // reset while stalled discards held data
    sel = 2'd0;
    in_valid = 4'b0001;
    tick();
    chk("mid_load", 32'(out_valid), 1);
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_ready", 32'(in_ready), 0);
    tick();
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_data", 32'(out_data), 0);
    reset = 1'b0;
    // three-channel instance: selector 3 is out of range
    sel3 = 2'd2;
    in_valid3 = 3'b111;
    #1;
    chk("c3_ready", 32'(in_ready3), 32'b100);
    tick();
    chk("c3_valid", 32'(out_valid3), 1);
    chk("c3_data", 32'(out_data3), 32'h2222);
    sel3 = 2'd3;
    #1;
    chk("c3_oor_ready", 32'(in_ready3), 0);
    tick();
    chk("c3_oor_valid", 32'(out_valid3), 0);
    chk("c3_oor_grant", 32'(grant3), 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_mux_arb.md
Name: operand_mux_arb

Overview:
- Parametrised N-channel, W-bit registered operand multiplexer for the accumulator datapath.
- Successor to the combinational 2:1 16-bit operand select.
- Adds valid/ready handshakes on every input and the output, a one-entry registered output stage, and two selection modes: directed (by Selector) and round-robin arbitration.
- Sits between operand sources (register file, sign extender, immediate, memory read) and the ALU/accumulator input.

Parameters:
- WIDTH, 16, data width of every channel and of the output.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(CHANNELS), width of Selector and Grant; derived, not overridden.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Mode  input  1  0 = directed select, 1 = round-robin arbitration; sampled every cycle.
- Selector  input  SEL_W  channel index used in directed mode.
- InValid  input  CHANNELS  per-channel data-valid.
- InData  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- InReady  output  CHANNELS  per-channel accept strobe; combinational, one-hot or zero.
- OutValid  output  1  output register holds valid data.
- OutData  output  WIDTH  registered selected data.
- OutReady  input  1  downstream accepts OutData this cycle.
- Grant  output  SEL_W  index of the channel that supplied the current OutData (registered).

Behaviour:
- Reset (synchronous, active-high; CLK, Reset; polarity and synchronicity fixed):
  - OutValid=0, OutData=0, Grant=0, round-robin pointer Last=CHANNELS-1, so the first search starts at channel 0.
  - Reset mid-transfer discards held data. InReady is 0 while Reset=1.
- Slot free: Free = !OutValid || OutReady.
- Candidate selection, combinational:
  - Mode=0: candidate = Selector if Selector < CHANNELS and InValid[Selector]=1, else none.
  - Mode=1: candidate = first i with InValid[i]=1, searching Last+1, Last+2, … modulo CHANNELS, wrapping. None if InValid is all 0.
- Accept: when Free and a candidate c exists, InReady[c]=1 and all other InReady bits are 0. The transfer on channel c occurs this cycle.
- On accept:
  - Next edge: OutData <= InData[c], Grant <= c, OutValid <= 1.
  - In Mode=1 only: Last <= c.
- On OutReady=1 with no accept: OutValid <= 0. OutData and Grant hold their last values.
- While OutValid=1 and OutReady=0:
  - OutData and Grant are held stable and InReady = 0.
  - Producers must hold InValid/InData (standard valid/ready; valid must not drop before ready).
- Latency and throughput: 1 cycle input-to-output. Full throughput of 1 word/cycle with OutReady held 1 (simultaneous drain and refill).
- Directed mode never updates Last. Switching Mode takes effect the same cycle; Last is kept from the last round-robin grant.
- Out-of-range Selector (CHANNELS not a power of two): no grant, no state change, no error flag.
- Fairness: in Mode=1 with all channels continuously valid, grants cycle 0,1,…,CHANNELS-1,0,…
- No combinational path from InData to OutData. The only combinational paths are InValid/Selector/Mode/OutReady -> InReady.

Decomposition:
- Shared package (operand_pkg): mode encodings MODE_DIRECT=1'b0 and MODE_RR=1'b1; default WIDTH=16.
- One natural sub-module: rr_pick, a combinational rotate-priority encoder.
  - Inputs: request vector, Last.
  - Outputs: found, index.
- Top level holds the output register, Last and the handshake logic.

Test Plan:
- Reset: drive Reset=1 for 2 cycles with InValid=4'hF -> OutValid=0, OutData=0, Grant=0, InReady=0. After release, the first round-robin grant is channel 0.
- Directed, back-to-back:
  - Setup: Mode=0, OutReady=1, InValid=4'hF, InData ch0..3 = 16'h0A0A/16'h1B1B/16'h2C2C/16'h3D3D.
  - Stimulus: Selector=2 for 3 cycles.
  - Required: InReady=4'b0100 each cycle; OutData=16'h2C2C, Grant=2 with OutValid=1 from cycle +1, one word per cycle.
- Round-robin fairness: Mode=1, all four channels valid, OutReady=1 -> Grant sequence 0,1,2,3,0,1 on consecutive cycles.
- Round-robin wrap and skip:
  - Setup: InValid=4'b1001, Last=0.
  - Required: grants 3,0,3,0. Channels 1 and 2 never get InReady.
- Backpressure:
  - Stimulus: OutValid=1, OutData=16'h1B1B, hold OutReady=0 for 4 cycles while InValid changes.
  - Required: OutData/Grant stable, InReady=0.
  - Then raise OutReady=1 with InValid[3]=1 (Mode=0, Selector=3) -> same-cycle InReady=4'b1000, next OutData=16'h3D3D.
- Edge cases:
  - CHANNELS=3, Mode=0, Selector=3 -> InReady=0; OutValid drops after drain.
  - Reset asserted while OutValid=1, OutReady=0 -> OutValid=0 next edge.
